// File: rtl/divclk_monitor_if.sv
// -----------------------------------------------------------------------------
// divclk_monitor_if
// Bundles the divided-clock observation inputs and the measurement results of
// divclk_monitor.
//   clk_div    : divided clock from the divider's clk_out
//   scale      : 8-bit division setting, same bus as the divider's scale input
//   period     : last rising-to-rising interval, in clk_in cycles
//   high_time  : last high phase, in clk_in cycles
//   meas_valid : one-cycle pulse when period/high_time update
//   locked     : consecutive periods agree
//   stalled    : no divided-clock rising edge within the timeout
//   mismatch   : period differs from 2*(scale+1) (zero unless the check is built)
// Modports: master = stimulus / divider side, slave = the monitor.
// -----------------------------------------------------------------------------
interface divclk_monitor_if #(
   parameter int unsigned CNT_W = 16
) ();
   logic             clk_div;
   logic [7:0]       scale;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             locked;
   logic             stalled;
   logic             mismatch;

   modport master (
      output clk_div, scale,
      input  period, high_time, meas_valid, locked, stalled, mismatch
   );

   modport slave (
      input  clk_div, scale,
      output period, high_time, meas_valid, locked, stalled, mismatch
   );
endinterface

// File: rtl/divclk_monitor.sv
// -----------------------------------------------------------------------------
// divclk_monitor
// Measures period and high time of a divided clock in clk_in cycles, reports
// lock once LOCK_CNT consecutive periods agree, and flags a stalled divided
// clock when no rising edge arrives within TIMEOUT cycles.
// Ports:
//   clk_in : system clock (same clock as the divider)
//   rst    : synchronous reset, active-high
//   bus    : divclk_monitor_if.slave (clk_div, scale in; results out)
// Parameters: CNT_W (counter/output width), TIMEOUT (< 2^CNT_W-1),
//             LOCK_CNT (1..15).
// Optional build macro: DIVCLK_EXPECT_CHECK_EN builds the period-vs-scale
// comparator driving mismatch; without it mismatch is tied to 0.
// -----------------------------------------------------------------------------
module divclk_monitor #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned TIMEOUT  = 1000,
   parameter int unsigned LOCK_CNT = 4
) (
   input  logic            clk_in,
   input  logic            rst,
   divclk_monitor_if.slave bus
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StMeas  = 2'd1;
   localparam logic [1:0] StStall = 2'd2;

   localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);
   localparam logic [3:0]       LockSat  = 4'(LOCK_CNT);
   localparam logic [3:0]       LockTgt  = 4'(LOCK_CNT - 1);

   logic             r_d1, r_d2;
   logic [CNT_W-1:0] r_cnt, r_hcnt;
   logic [1:0]       r_state;
   logic [7:0]       r_scale_q;
   logic [CNT_W-1:0] r_period, r_high_time;
   logic             r_meas_valid, r_locked, r_stalled;
   logic [3:0]       r_mcnt;
   logic             r_hist_valid;

   logic             w_rise, w_scale_chg, w_timeout, w_same;
   logic [CNT_W-1:0] w_cnt_inc, w_hcnt_inc;
   logic [CNT_W-1:0] w_cnt_nxt, w_hcnt_nxt;
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] w_period_nxt, w_high_time_nxt;
   logic             w_meas_valid_nxt, w_locked_nxt, w_stalled_nxt;
   logic [3:0]       w_mcnt_nxt;
   logic             w_hist_valid_nxt;

   assign w_rise      = r_d1 & ~r_d2;
   assign w_scale_chg = (bus.scale != r_scale_q);
   assign w_timeout   = (r_cnt == TimeoutC);
   // Only compare against r_period once a measurement exists in this run.
   assign w_same      = r_hist_valid && (r_cnt == r_period);

   always_comb begin
      w_cnt_inc  = (r_cnt  == CntMax) ? r_cnt  : r_cnt  + CntOne;
      w_hcnt_inc = (r_hcnt == CntMax) ? r_hcnt : r_hcnt + CntOne;
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = w_rise ? CntOne : w_cnt_inc;
      w_hcnt_nxt       = w_rise ? CntOne : (r_d1 ? w_hcnt_inc : r_hcnt);
      w_period_nxt     = r_period;
      w_high_time_nxt  = r_high_time;
      w_meas_valid_nxt = 1'b0;
      w_locked_nxt     = r_locked;
      w_stalled_nxt    = r_stalled;
      w_mcnt_nxt       = r_mcnt;
      w_hist_valid_nxt = r_hist_valid;

      if (w_scale_chg) begin
         // Drop the partial interval; results hold, lock/stall state restarts.
         w_state_nxt      = StIdle;
         w_cnt_nxt        = '0;
         w_hcnt_nxt       = '0;
         w_locked_nxt     = 1'b0;
         w_stalled_nxt    = 1'b0;
         w_mcnt_nxt       = '0;
         w_hist_valid_nxt = 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_rise) begin
                  w_state_nxt = StMeas;
               end else if (w_timeout) begin
                  w_state_nxt      = StStall;
                  w_stalled_nxt    = 1'b1;
                  w_locked_nxt     = 1'b0;
                  w_mcnt_nxt       = '0;
                  w_hist_valid_nxt = 1'b0;
               end
            end
            StMeas: begin
               if (w_rise) begin
                  // Counters still hold the closing interval's values here.
                  w_period_nxt     = r_cnt;
                  w_high_time_nxt  = r_hcnt;
                  w_meas_valid_nxt = 1'b1;
                  w_hist_valid_nxt = 1'b1;
                  if (w_same) begin
                     w_mcnt_nxt = (r_mcnt < LockSat) ? r_mcnt + 4'd1 : r_mcnt;
                  end else begin
                     w_mcnt_nxt = '0;
                  end
                  w_locked_nxt = (w_mcnt_nxt >= LockTgt);
               end else if (w_timeout) begin
                  w_state_nxt      = StStall;
                  w_stalled_nxt    = 1'b1;
                  w_locked_nxt     = 1'b0;
                  w_mcnt_nxt       = '0;
                  w_hist_valid_nxt = 1'b0;
               end
            end
            StStall: begin
               // The recovering edge only opens a fresh interval.
               if (w_rise) begin
                  w_state_nxt   = StMeas;
                  w_stalled_nxt = 1'b0;
               end
            end
            default: begin
               w_state_nxt = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      r_scale_q <= bus.scale;
      if (rst) begin
         r_d1         <= 1'b0;
         r_d2         <= 1'b0;
         r_cnt        <= '0;
         r_hcnt       <= '0;
         r_state      <= StIdle;
         r_period     <= '0;
         r_high_time  <= '0;
         r_meas_valid <= 1'b0;
         r_locked     <= 1'b0;
         r_stalled    <= 1'b0;
         r_mcnt       <= '0;
         r_hist_valid <= 1'b0;
      end else begin
         r_d1         <= bus.clk_div;
         r_d2         <= r_d1;
         r_cnt        <= w_cnt_nxt;
         r_hcnt       <= w_hcnt_nxt;
         r_state      <= w_state_nxt;
         r_period     <= w_period_nxt;
         r_high_time  <= w_high_time_nxt;
         r_meas_valid <= w_meas_valid_nxt;
         r_locked     <= w_locked_nxt;
         r_stalled    <= w_stalled_nxt;
         r_mcnt       <= w_mcnt_nxt;
         r_hist_valid <= w_hist_valid_nxt;
      end
   end

   assign bus.period     = r_period;
   assign bus.high_time  = r_high_time;
   assign bus.meas_valid = r_meas_valid;
   assign bus.locked     = r_locked;
   assign bus.stalled    = r_stalled;

`ifdef DIVCLK_EXPECT_CHECK_EN
   logic [CNT_W-1:0] w_expect;
   logic             r_mismatch, w_mismatch_nxt;

   // Divider output period is 2*(scale+1) clk_in cycles.
   assign w_expect = CNT_W'({r_scale_q, 1'b0}) + CNT_W'(2);

   always_comb begin
      w_mismatch_nxt = r_mismatch;
      if (w_scale_chg) begin
         w_mismatch_nxt = 1'b0;
      end else if (w_meas_valid_nxt) begin
         w_mismatch_nxt = (r_cnt != w_expect);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_mismatch <= 1'b0;
      end else begin
         r_mismatch <= w_mismatch_nxt;
      end
   end

   assign bus.mismatch = r_mismatch;
`else
   assign bus.mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_divclk_monitor.sv
// -----------------------------------------------------------------------------
// tb_divclk_monitor
// Drives divclk_monitor through reset, steady 4/4 clocks, a period glitch, a
// stall, scale changes, randomized waveforms and a mid-run reset. A
// cycle-level reference model derived from the measurement rules is compared
// against every output on every cycle, plus literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_divclk_monitor;
   localparam int CNT_W    = 16;
   localparam int TIMEOUT  = 1000;
   localparam int LOCK_CNT = 4;
   localparam int SAT      = (1 << CNT_W) - 1;

   logic clk_in = 1'b0;
   logic rst    = 1'b0;

   divclk_monitor_if #(.CNT_W(CNT_W)) bus ();

   divclk_monitor #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT),
      .LOCK_CNT(LOCK_CNT)
   ) dut (
      .clk_in(clk_in),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // e[k] is the clk_div level seen by the monitor at edge k (0 while in reset).
   bit          e [0:65535];
   int          k = 0;
   bit          model_on = 0;
   int          m_mode;          // 0 waiting for first edge, 1 measuring, 2 stalled
   int          ref_k;           // counter value at edge n is n - ref_k
   logic [15:0] m_period, m_high;
   bit          m_mv, m_locked, m_stalled, m_mism;
   logic [7:0]  m_scale_q;
   int          hist[$];

   task automatic measure();
      int per, hi, run;
      per = k - ref_k;
      if (per > SAT) per = SAT;
      hi = 0;
      for (int i = ref_k - 1; i <= k - 2; i++) if (e[i]) hi++;
      if (hi > SAT) hi = SAT;
      m_period = 16'(per);
      m_high   = 16'(hi);
      m_mv     = 1'b1;
      hist.push_back(per);
      if (hist.size() > LOCK_CNT) void'(hist.pop_front());
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] == per) run++;
         else break;
      end
      m_locked = (run >= LOCK_CNT);
`ifdef DIVCLK_EXPECT_CHECK_EN
      m_mism = (per != 2 * (int'(m_scale_q) + 1));
`endif
   endtask

   task automatic model_step();
      bit rise, chg;
      int cnt;
      if (rst) model_on = 1'b1;
      if (model_on) begin
         m_mv = 1'b0;
         if (rst) begin
            m_period = '0; m_high = '0; m_locked = 0; m_stalled = 0; m_mism = 0;
            m_mode = 0; ref_k = k + 1; hist.delete();
            e[k] = 1'b0;
         end else begin
            rise = (k >= 2) && e[k-1] && !e[k-2];
            chg  = (bus.scale != m_scale_q);
            cnt  = k - ref_k;
            if (cnt > SAT) cnt = SAT;
            if (chg) begin
               m_mode = 0; m_locked = 0; m_stalled = 0; m_mism = 0;
               hist.delete(); ref_k = k + 1;
            end else if (rise) begin
               if (m_mode == 1) measure();
               m_mode = 1; m_stalled = 0; ref_k = k;
            end else if (m_mode != 2 && cnt == TIMEOUT) begin
               m_mode = 2; m_stalled = 1; m_locked = 0; hist.delete();
            end
            e[k] = bus.clk_div;
         end
         m_scale_q = bus.scale;
      end
      k++;
   endtask

   initial forever begin
      @(posedge clk_in);
      model_step();
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      wait (model_on);
      forever begin
         @(negedge clk_in);
         chk("period",     32'(bus.period),     32'(m_period));
         chk("high_time",  32'(bus.high_time),  32'(m_high));
         chk("meas_valid", 32'(bus.meas_valid), 32'(m_mv));
         chk("locked",     32'(bus.locked),     32'(m_locked));
         chk("stalled",    32'(bus.stalled),    32'(m_stalled));
         chk("mismatch",   32'(bus.mismatch),   32'(m_mism));
      end
   end

   // ---------------- stimulus side observation ----------------
   typedef struct {
      int per;
      int hi;
      bit lock;
      bit mism;
   } meas_t;

   meas_t mq[$];
   int    ncyc = 0, valid_idx = 0, stall_idx = 0;
   bit    prev_st = 0;

   function automatic meas_t mget(input int i);
      meas_t r;
      r = '{per: -1, hi: -1, lock: 1'b0, mism: 1'b0};
      if (i < mq.size()) r = mq[i];
      return r;
   endfunction

   task automatic obs();
      ncyc++;
      if (bus.meas_valid === 1'b1) begin
         mq.push_back('{per: int'(bus.period), hi: int'(bus.high_time),
                        lock: bus.locked, mism: bus.mismatch});
         valid_idx = ncyc;
      end
      if (bus.stalled === 1'b1 && !prev_st) stall_idx = ncyc;
      prev_st = (bus.stalled === 1'b1);
   endtask

   task automatic step(input logic v);
      @(negedge clk_in);
      obs();
      bus.clk_div = v;
   endtask

   task automatic run(input int hi, input int lo, input int n);
      repeat (n) begin
         repeat (hi) step(1'b1);
         repeat (lo) step(1'b0);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_period"},  32'(bus.period),     0);
      chk({tag, "_high"},    32'(bus.high_time),  0);
      chk({tag, "_valid"},   32'(bus.meas_valid), 0);
      chk({tag, "_locked"},  32'(bus.locked),     0);
      chk({tag, "_stalled"}, 32'(bus.stalled),    0);
      chk({tag, "_mism"},    32'(bus.mismatch),   0);
   endtask

   initial begin
      int stalls;
      bus.clk_div = 1'b1;
      bus.scale   = 8'd3;

      // Reset for three edges while clk_div changes underneath.
      step(1'b1);
      step(1'b1);
      rst = 1'b1;
      step(1'b1);
      chk_zero("reset");
      step(1'b0);
      step(1'b0);
      rst = 1'b0;

      // Steady 4/4 at scale 3: first result after the second rise, lock at 4th.
      mq.delete();
      run(4, 4, 6);
      chk("n_meas_4_4",   32'(mq.size()), 5);
      chk("first_period", 32'(mget(0).per), 8);
      chk("first_high",   32'(mget(0).hi), 4);
      chk("lock_at_3rd",  32'(mget(2).lock), 0);
      chk("lock_at_4th",  32'(mget(3).lock), 1);
      chk("mism_match",   32'(mget(3).mism), 0);

      // One 10-cycle interval breaks lock; four more 8s relock.
      mq.delete();
      run(5, 5, 1);
      run(4, 4, 5);
      chk("glitch_period", 32'(mget(1).per), 10);
      chk("glitch_unlock", 32'(mget(1).lock), 0);
      chk("relock_pend",   32'(mget(4).lock), 0);
      chk("relock",        32'(mget(5).lock), 1);

      // Stuck high: stall exactly TIMEOUT cycles after the last reload.
      mq.delete();
      repeat (TIMEOUT + 10) step(1'b1);
      chk("stall_delay",   32'(stall_idx - valid_idx), 32'(TIMEOUT));
      chk("stall_flag",    32'(bus.stalled), 1);
      chk("stall_unlock",  32'(bus.locked), 0);
      chk("stall_holdper", 32'(bus.period), 8);
      mq.delete();
      run(4, 4, 4);
      chk("resume_nmeas",  32'(mq.size()), 2);
      chk("resume_period", 32'(mget(0).per), 8);
      chk("resume_stall",  32'(bus.stalled), 0);

      // Lock again, then change scale 3->7 mid-interval.
      run(4, 4, 5);
      chk("prechg_lock", 32'(bus.locked), 1);
      repeat (4) step(1'b1);
      step(1'b0);
      step(1'b0);
      mq.delete();
      bus.scale = 8'd7;
      step(1'b0);
      step(1'b0);
      chk("chg_holdper", 32'(bus.period), 8);
      chk("chg_unlock",  32'(bus.locked), 0);
      chk("chg_nomeas",  32'(mq.size()), 0);
      run(8, 8, 3);
      chk("s7_nmeas",  32'(mq.size()), 2);
      chk("s7_period", 32'(mget(0).per), 16);
      chk("s7_high",   32'(mget(0).hi), 8);
      chk("s7_mism",   32'(mget(1).mism), 0);
      mq.delete();
      run(4, 4, 3);
`ifdef DIVCLK_EXPECT_CHECK_EN
      chk("s7_4_4_mism", 32'(mget(2).mism), 1);
`else
      chk("s7_4_4_mism", 32'(mget(2).mism), 0);
`endif

      // Randomized waveforms and scale moves, checked by the model.
      stalls = 0;
      for (int it = 0; it < 60; it++) begin
         int sel;
         sel = int'($urandom_range(0, 19));
         if (sel == 0) begin
            bus.scale = 8'($urandom_range(0, 15));
            step(bus.clk_div);
         end else if (sel == 1 && stalls < 1) begin
            stalls++;
            repeat (TIMEOUT + 5) step(bus.clk_div);
         end else begin
            run(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)),
                int'($urandom_range(1, 5)));
         end
      end

      // Lock, then reset mid-measurement.
      bus.scale = 8'd3;
      step(1'b0);
      run(4, 4, 7);
      chk("prerst_lock", 32'(bus.locked), 1);
      step(1'b1);
      step(1'b1);
      rst = 1'b1;
      step(1'b1);
      chk_zero("midrst");
      rst = 1'b0;
      mq.delete();
      repeat (3) step(1'b1);
      chk("postrst_nomeas", 32'(mq.size()), 0);
      run(4, 4, 3);
      chk("postrst_period", 32'(mget(1).per), 8);

      repeat (3) step(1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/divclk_monitor.md
Name: divclk_monitor

Overview:
- Sits directly downstream of the clock divider, in the clk_in domain. It consumes the divider's clk_out together with the same 8-bit scale word that drives the divider.
- Measures the period and high time of the divided clock in clk_in cycles. Reports lock once consecutive periods agree, and flags a stalled (stuck-high or stuck-low) divided clock.
- Results drive status pins and debug readout at the top level.

Parameters:
- CNT_W, 16, width of the period and high-time counters and outputs.
- TIMEOUT, 1000, clk_in cycles without a divided-clock rising edge before stall is declared. Must be less than 2^CNT_W-1.
- LOCK_CNT, 4, number of consecutive identical period measurements required to assert locked. Range 1..15.

Ports:
- clk_in, input, 1, system clock; same clock as the divider.
- rst, input, 1, synchronous reset, active-high.
- clk_div, input, 1, divided clock from the divider's clk_out.
- scale, input, 8, division setting; same bus as the divider's scale input.
- period, output, CNT_W, last measured rising-to-rising interval in clk_in cycles.
- high_time, output, CNT_W, last measured high phase in clk_in cycles.
- meas_valid, output, 1, one-cycle pulse when period/high_time update.
- locked, output, 1, stable-period indicator.
- stalled, output, 1, no divided-clock edge within TIMEOUT.
- mismatch, output, 1, period differs from the expected value (optional feature).

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While rst=1 at a clk_in edge, these outputs go to 0: period, high_time, meas_valid, locked, stalled, mismatch. Also: internal counters clear, history flops clear, scale_q loads scale, FSM enters IDLE.
- Edge detection:
  - d1 registers clk_div; d2 registers d1.
  - rise = d1 & ~d2.
  - rise is seen 2 clk_in edges after clk_div rises.
- Counters:
  - On a rise cycle: cnt loads 1 and hcnt loads 1.
  - Otherwise: cnt increments; hcnt increments only while d1=1.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- FSM states: IDLE, MEAS, STALL.
  - IDLE: wait for first rise. On rise go to MEAS with no measurement output. In IDLE, cnt counts toward TIMEOUT; reaching it moves to STALL.
  - MEAS, on rise: period<=cnt and high_time<=hcnt (pre-reload values). meas_valid=1 on the following cycle, aligned with the updated outputs. Stay in MEAS.
  - MEAS, no rise and cnt==TIMEOUT: go to STALL. stalled<=1, locked<=0, lock history cleared.
  - STALL: stalled held at 1. On next rise, stalled<=0 and go to MEAS. That rise starts a fresh interval; no meas_valid is issued for it.
- Lock:
  - Match counter mcnt increments when a new period equals the previous period, saturating at LOCK_CNT.
  - Any differing period sets mcnt=0 and locked=0.
  - locked=1 when mcnt reaches LOCK_CNT-1 matches (LOCK_CNT consecutive equal periods, counting the first).
  - For LOCK_CNT=1, locked asserts with the first valid measurement.
- Scale change: scale is registered into scale_q every cycle. If scale != scale_q:
  - FSM goes to IDLE; locked<=0; mcnt<=0.
  - The partial interval is discarded.
  - period and high_time hold their last values.
  - stalled is cleared.
- Simultaneous events:
  - rst has priority over everything.
  - Scale change has priority over rise and timeout in the same cycle.
  - Rise has priority over timeout in the same cycle.
- Constant clk_div, high or low: no rise, so stall after TIMEOUT cycles. Outputs keep their last measurement.

Optional Feature:
- Macro: DIVCLK_EXPECT_CHECK_EN.
- With the macro defined: expected period = 2*(scale_q+1). mismatch is registered with each meas_valid: 1 if period != expected, else 0. mismatch holds until the next measurement, a scale change, or reset; scale change and reset clear it.
- Without the macro: mismatch is tied to 0 and the comparator logic is not built.

Test Plan:
- rst=1 for 3 cycles with clk_div toggling -> all outputs 0 during and after reset until the first full interval completes.
- scale=3, clk_div 4 high/4 low -> first meas_valid after the second rise, with period=8 and high_time=4. locked=1 at the 4th valid measurement (LOCK_CNT=4). mismatch=0 with DIVCLK_EXPECT_CHECK_EN defined.
- Locked at period 8, then one 10-cycle interval -> period=10 with meas_valid, locked=0. Relocks after 4 more equal measurements.
- clk_div held high, TIMEOUT=1000 -> stalled=1 exactly 1000 cycles after the last rise reload, locked=0. Toggling resumes -> stalled=0 on the next rise, no meas_valid for that rise, next interval measured normally.
- scale changes 3->7 mid-interval -> locked=0, no meas_valid for the partial interval, period holds 8. With clk_div 8/8, period=16 after two rises; mismatch=0. With the check enabled and clk_div left at 4/4, mismatch=1.
- rst asserted mid-measurement while locked -> next cycle all outputs 0 and FSM in IDLE. First rise after reset produces no meas_valid.
